// File: rtl/clk_div_pkg.sv
// Shared constants and helpers for the multi-channel integer clock divider.
package clk_div_pkg;

  localparam int unsigned DIV_MIN = 2;

  // Ratios below DIV_MIN cannot form a square wave, so they are raised to it.
  function automatic int unsigned div_clamp(input int unsigned v);
    return (v < DIV_MIN) ? DIV_MIN : v;
  endfunction

  // Odd ratios put the extra cycle in the high phase.
  function automatic int unsigned hi_len(input int unsigned d);
    return d - (d / 2);
  endfunction

endpackage

// File: rtl/clk_div_multi_if.sv
// Control and output bundle of the multi-channel clock divider.
interface clk_div_multi_if #(
  parameter int N_CH  = 2,
  parameter int DIV_W = 8
);

  logic [N_CH*DIV_W-1:0] div_val;
  logic [N_CH-1:0]       div_load;
  logic [N_CH-1:0]       ch_en;
  logic                  sync_req;
  logic [N_CH-1:0]       clk_out;
  logic [N_CH-1:0]       ce_out;
  logic [N_CH-1:0]       upd_pend;

  modport master (
    output div_val, div_load, ch_en, sync_req,
    input  clk_out, ce_out, upd_pend
  );

  modport slave (
    input  div_val, div_load, ch_en, sync_req,
    output clk_out, ce_out, upd_pend
  );

endinterface

// File: rtl/clk_div_ch.sv
// One divider channel: period counter, shadow ratio with boundary update, registered outputs.
module clk_div_ch
  import clk_div_pkg::*;
#(
  parameter int DIV_W = 8
) (
  input  logic             clk_in,
  input  logic             rest_n,
  input  logic             en,
  input  logic             sync,
  input  logic             load,
  input  logic [DIV_W-1:0] val,
  input  logic [DIV_W-1:0] init,
  output logic             clk_out,
  output logic             ce_out,
  output logic             upd_pend
);

  logic [DIV_W-1:0] cnt, cnt_n;
  logic [DIV_W-1:0] div_q, div_n;
  logic [DIV_W-1:0] shadow, shadow_n;
  logic             clk_n, ce_n, pend_n;
  logic [DIV_W-1:0] val_c, init_c, hi, last;
  logic             wrap;

  assign val_c  = DIV_W'(div_clamp(32'(val)));
  assign init_c = DIV_W'(div_clamp(32'(init)));
  assign hi     = DIV_W'(hi_len(32'(div_q)));
  assign last   = div_q - DIV_W'(1);
  assign wrap   = (cnt == last);

  // A same-cycle load bypasses the shadow so the freshest ratio is what gets applied.
  always_comb begin
    cnt_n    = cnt;
    div_n    = div_q;
    shadow_n = shadow;
    clk_n    = clk_out;
    ce_n     = ce_out;
    pend_n   = upd_pend;
    if (sync || !en) begin
      cnt_n    = '0;
      clk_n    = 1'b0;
      ce_n     = 1'b0;
      div_n    = load ? val_c : shadow;
      shadow_n = div_n;
      pend_n   = 1'b0;
    end else begin
      cnt_n = wrap ? '0 : cnt + DIV_W'(1);
      clk_n = (cnt < hi);
      ce_n  = wrap;
      if (wrap) begin
        div_n    = load ? val_c : shadow;
        shadow_n = div_n;
        pend_n   = 1'b0;
      end else if (load) begin
        shadow_n = val_c;
        pend_n   = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_in) begin
    if (!rest_n) begin
      cnt      <= '0;
      div_q    <= init_c;
      shadow   <= init_c;
      clk_out  <= 1'b0;
      ce_out   <= 1'b0;
      upd_pend <= 1'b0;
    end else begin
      cnt      <= cnt_n;
      div_q    <= div_n;
      shadow   <= shadow_n;
      clk_out  <= clk_n;
      ce_out   <= ce_n;
      upd_pend <= pend_n;
    end
  end

endmodule

// File: rtl/clk_div_multi.sv
// N-channel programmable clock divider; each channel is an independent clk_div_ch.
module clk_div_multi
  import clk_div_pkg::*;
#(
  parameter int                    N_CH     = 2,
  parameter int                    DIV_W    = 8,
  parameter logic [N_CH*DIV_W-1:0] DIV_INIT = {8'd10, 8'd4}
) (
  input logic            clk_in,
  input logic            rest_n,
  clk_div_multi_if.slave bus
);

  for (genvar k = 0; k < N_CH; k++) begin : g_ch
    clk_div_ch #(
      .DIV_W(DIV_W)
    ) u_ch (
      .clk_in  (clk_in),
      .rest_n  (rest_n),
      .en      (bus.ch_en[k]),
      .sync    (bus.sync_req),
      .load    (bus.div_load[k]),
      .val     (bus.div_val[k*DIV_W +: DIV_W]),
      .init    (DIV_INIT[k*DIV_W +: DIV_W]),
      .clk_out (bus.clk_out[k]),
      .ce_out  (bus.ce_out[k]),
      .upd_pend(bus.upd_pend[k])
    );
  end

endmodule

// File: tb/tb_clk_div_multi.sv
// Directed bench for clk_div_multi: per-cycle scoreboard against a behavioural model plus waveform checks.
module tb_clk_div_multi;

  localparam int N_CH  = 2;
  localparam int DIV_W = 8;

  logic clk_in = 1'b0;
  logic rest_n;

  clk_div_multi_if #(.N_CH(N_CH), .DIV_W(DIV_W)) bus ();

  clk_div_multi #(
    .N_CH    (N_CH),
    .DIV_W   (DIV_W),
    .DIV_INIT({8'd10, 8'd4})
  ) dut (
    .clk_in(clk_in),
    .rest_n(rest_n),
    .bus   (bus)
  );

  always #5 clk_in = ~clk_in;

  int checks = 0;
  int errors = 0;
  logic [5:0] sb[$];

  int         m_cnt[N_CH];
  int         m_d[N_CH];
  int         m_sh[N_CH];
  int         init_d[N_CH] = '{4, 10};
  logic [1:0] m_clk, m_ce, m_pend;

  logic [31:0] h0, h1, c0, c1;
  int          pend0_seen;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // Cycle model of one clock edge, written from the behavioural description.
  task automatic model_tick();
    int v;
    for (int k = 0; k < N_CH; k++) begin
      v = int'(bus.div_val[k*DIV_W +: DIV_W]);
      if (v < 2) v = 2;
      if (!rest_n) begin
        m_cnt[k] = 0; m_d[k] = init_d[k]; m_sh[k] = init_d[k];
        m_clk[k] = 1'b0; m_ce[k] = 1'b0; m_pend[k] = 1'b0;
      end else if (bus.sync_req || !bus.ch_en[k]) begin
        m_cnt[k] = 0; m_clk[k] = 1'b0; m_ce[k] = 1'b0;
        m_d[k] = bus.div_load[k] ? v : m_sh[k];
        m_sh[k] = m_d[k];
        m_pend[k] = 1'b0;
      end else begin
        m_clk[k] = (m_cnt[k] < (m_d[k] + 1) / 2);
        m_ce[k]  = (m_cnt[k] == m_d[k] - 1);
        if (m_ce[k]) begin
          m_cnt[k] = 0;
          m_d[k] = bus.div_load[k] ? v : m_sh[k];
          m_sh[k] = m_d[k];
          m_pend[k] = 1'b0;
        end else begin
          m_cnt[k] = m_cnt[k] + 1;
          if (bus.div_load[k]) begin
            m_sh[k] = v;
            m_pend[k] = 1'b1;
          end
        end
      end
    end
  endtask

  task automatic step(input string tag);
    logic [5:0] e;
    model_tick();
    sb.push_back({m_clk, m_ce, m_pend});
    @(posedge clk_in);
    #1;
    e = sb.pop_front();
    check(tag, 32'({bus.clk_out, bus.ce_out, bus.upd_pend}), 32'(e));
    h0 = {h0[30:0], bus.clk_out[0]};
    h1 = {h1[30:0], bus.clk_out[1]};
    c0 = {c0[30:0], bus.ce_out[0]};
    c1 = {c1[30:0], bus.ce_out[1]};
    if (bus.upd_pend[0]) pend0_seen++;
  endtask

  initial begin
    h0 = '0; h1 = '0; c0 = '0; c1 = '0; pend0_seen = 0;
    rest_n       = 1'b0;
    bus.div_val  = '0;
    bus.div_load = '0;
    bus.ch_en    = 2'b11;
    bus.sync_req = 1'b0;
    $display("[TB] start");

    step("reset");
    step("reset");
    check("reset_outs", 32'({bus.clk_out, bus.ce_out, bus.upd_pend}), 32'd0);

    rest_n = 1'b1;
    repeat (20) step("t1_run");
    check("t1_ch0_wave", 32'(h0[19:0]), 32'(20'b11001100110011001100));
    check("t1_ch0_ce",   32'(c0[19:0]), 32'(20'b00010001000100010001));
    check("t1_ch1_wave", 32'(h1[19:0]), 32'(20'b11111000001111100000));
    check("t1_ch1_ce",   32'(c1[19:0]), 32'(20'b00000000010000000001));

    step("t2_pre");
    pend0_seen = 0;
    bus.div_val[7:0] = 8'd5; bus.div_load = 2'b01;
    step("t2_load");
    bus.div_load = 2'b00;
    step("t2_wait");
    step("t2_wrap");
    check("t2_pend_cycles", 32'(pend0_seen), 32'd2);
    check("t2_pend_clear", 32'(bus.upd_pend[0]), 32'd0);
    repeat (10) step("t2_d5");
    check("t2_d5_wave", 32'(h0[9:0]), 32'(10'b1110011100));
    check("t2_d5_ce",   32'(c0[9:0]), 32'(10'b0000100001));

    repeat (4) step("t3_pre");
    pend0_seen = 0;
    bus.div_val[7:0] = 8'd3; bus.div_load = 2'b01;
    step("t3_wrapload");
    bus.div_load = 2'b00;
    repeat (6) step("t3_d3");
    check("t3_no_pend", 32'(pend0_seen), 32'd0);
    check("t3_d3_wave", 32'(h0[5:0]), 32'(6'b110110));
    bus.div_val[7:0] = 8'd6; bus.div_load = 2'b01;
    step("t3_load6");
    bus.div_val[7:0] = 8'd7;
    step("t3_load7");
    bus.div_load = 2'b00;
    step("t3_wrap");
    repeat (7) step("t3_d7");
    check("t3_d7_wave", 32'(h0[6:0]), 32'(7'b1111000));
    check("t3_d7_ce",   32'(c0[6:0]), 32'(7'b0000001));

    bus.div_val[7:0] = 8'd0; bus.div_load = 2'b01;
    step("t4_load0");
    bus.div_load = 2'b00;
    repeat (6) step("t4_wait0");
    repeat (6) step("t4_d2_from0");
    check("t4_zero_wave", 32'(h0[5:0]), 32'(6'b101010));
    check("t4_zero_ce",   32'(c0[5:0]), 32'(6'b010101));
    bus.div_val[7:0] = 8'd1; bus.div_load = 2'b01;
    step("t4_load1");
    bus.div_load = 2'b00;
    step("t4_wrap1");
    repeat (6) step("t4_d2_from1");
    check("t4_one_wave", 32'(h0[5:0]), 32'(6'b101010));
    check("t4_one_ce",   32'(c0[5:0]), 32'(6'b010101));

    repeat (3) step("t5_pre");
    bus.div_val[7:0] = 8'd4; bus.div_load = 2'b01; bus.sync_req = 1'b1;
    step("t5_sync");
    check("t5_sync_low", 32'(bus.clk_out), 32'(2'b00));
    bus.div_load = 2'b00; bus.sync_req = 1'b0;
    step("t5_rise");
    check("t5_rise_both", 32'(bus.clk_out), 32'(2'b11));
    repeat (7) step("t5_run");
    check("t5_ch0_wave", 32'(h0[7:0]), 32'(8'b11001100));
    check("t5_ch1_wave", 32'(h1[7:0]), 32'(8'b11111000));

    step("t6_pre");
    bus.ch_en = 2'b10;
    step("t6_dis");
    check("t6_drop_low", 32'(bus.clk_out[0]), 32'd0);
    bus.div_val[7:0] = 8'd6; bus.div_load = 2'b01;
    step("t6_dis_load");
    bus.div_load = 2'b00;
    step("t6_dis");
    bus.ch_en = 2'b11;
    repeat (6) step("t6_reen");
    check("t6_reen_wave", 32'(h0[5:0]), 32'(6'b111000));
    check("t6_reen_ce",   32'(c0[5:0]), 32'(6'b000001));
    step("t6_mid");
    bus.div_val[15:8] = 8'd20; bus.div_load = 2'b10;
    step("t6_load_ch1");
    bus.div_load = 2'b00;
    rest_n = 1'b0;
    step("t6_reset");
    check("t6_reset_outs", 32'({bus.clk_out, bus.ce_out, bus.upd_pend}), 32'd0);
    rest_n = 1'b1;
    repeat (8) step("t6_after");
    check("t6_ch0_init", 32'(h0[7:0]), 32'(8'b11001100));
    check("t6_ch1_init", 32'(h1[7:0]), 32'(8'b11111000));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
